// File: rtl/nw_fill_ctrl.sv
// Needleman-Wunsch score matrix fill sequencer: boundary init, neighbour fetch, Max handshake, write-back.
// Optional Max-handshake watchdog with err output: define NW_TIMEOUT_EN.
module nw_fill_ctrl #(
  parameter int        N        = 8,
  parameter int        W        = 9,
  parameter int signed MATCH    = 1,
  parameter int signed MISMATCH = -1,
  parameter int signed GAP      = -2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [3:0]          row,
  output logic [3:0]          col,
  output logic                rd_en,
  input  logic signed [W-1:0] diag_s,
  input  logic signed [W-1:0] up_s,
  input  logic signed [W-1:0] lx_s,
  output logic [3:0]          a_addr,
  output logic [3:0]          b_addr,
  input  logic [1:0]          char_a,
  input  logic [1:0]          char_b,
  output logic                value,
  output logic signed [W-1:0] m_diag,
  output logic signed [W-1:0] m_up,
  output logic signed [W-1:0] m_lx,
  input  logic signed [W-1:0] max,
  input  logic [2:0]          symbol,
  input  logic                calculated,
  output logic                wr_en,
  output logic signed [W-1:0] wr_score,
  output logic [2:0]          wr_sym
`ifdef NW_TIMEOUT_EN
  ,
  output logic                err
`endif
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_INIT_ROW = 4'd1;
  localparam logic [3:0] S_INIT_COL = 4'd2;
  localparam logic [3:0] S_READ     = 4'd3;
  localparam logic [3:0] S_LOAD     = 4'd4;
  localparam logic [3:0] S_ISSUE    = 4'd5;
  localparam logic [3:0] S_WAIT     = 4'd6;
  localparam logic [3:0] S_WRITE    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [3:0]          LAST       = 4'(N);
  localparam logic signed [W-1:0] GAP_W      = W'(GAP);
  localparam logic signed [W-1:0] MATCH_W    = W'(MATCH);
  localparam logic signed [W-1:0] MISMATCH_W = W'(MISMATCH);

  logic [3:0]          state_q, state_d;
  logic [3:0]          row_q, row_d, col_q, col_d;
  logic signed [W-1:0] mdiag_q, mdiag_d, mup_q, mup_d, mlx_q, mlx_d;
  logic signed [W-1:0] res_score_q, res_score_d;
  logic [2:0]          res_sym_q, res_sym_d;
  logic [3:0]          init_idx;
  logic [W-1:0]        init_idx_w;
  logic signed [W-1:0] init_score;
  logic signed [W-1:0] bonus;
`ifdef NW_TIMEOUT_EN
  logic [3:0]          wd_q, wd_d;
  logic                err_q, err_d;
`endif

  // Widen by one bit, then clamp on sign disagreement instead of wrapping.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_add = s[W-1:0];
  endfunction

  always_comb begin
    init_idx   = (state_q == S_INIT_ROW) ? col_q : row_q;
    init_idx_w = W'(init_idx);
    init_score = GAP_W * $signed(init_idx_w);
    bonus      = (char_a == char_b) ? MATCH_W : MISMATCH_W;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    mdiag_d     = mdiag_q;
    mup_d       = mup_q;
    mlx_d       = mlx_q;
    res_score_d = res_score_q;
    res_sym_d   = res_sym_q;
`ifdef NW_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_INIT_ROW;
        row_d   = '0;
        col_d   = '0;
      end
      S_INIT_ROW: if (col_q == LAST) begin
        state_d = S_INIT_COL;
        row_d   = 4'd1;
        col_d   = '0;
      end else begin
        col_d = col_q + 4'd1;
      end
      S_INIT_COL: if (row_q == LAST) begin
        state_d = S_READ;
        row_d   = 4'd1;
        col_d   = 4'd1;
      end else begin
        row_d = row_q + 4'd1;
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        mdiag_d = sat_add(diag_s, bonus);
        mup_d   = sat_add(up_s, GAP_W);
        mlx_d   = sat_add(lx_s, GAP_W);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef NW_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: if (calculated) begin
        res_score_d = max;
        res_sym_d   = symbol;
        state_d     = S_WRITE;
      end
`ifdef NW_TIMEOUT_EN
      else if (wd_q == 4'd14) begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 4'd1;
      end
`endif
      S_WRITE: if (col_q == LAST) begin
        if (row_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          row_d   = row_q + 4'd1;
          col_d   = 4'd1;
        end
      end else begin
        state_d = S_READ;
        col_d   = col_q + 4'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mdiag_q     <= '0;
      mup_q       <= '0;
      mlx_q       <= '0;
      res_score_q <= '0;
      res_sym_q   <= '0;
`ifdef NW_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mdiag_q     <= mdiag_d;
      mup_q       <= mup_d;
      mlx_q       <= mlx_d;
      res_score_q <= res_score_d;
      res_sym_q   <= res_sym_d;
`ifdef NW_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    rd_en  = (state_q == S_READ);
    value  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    wr_en  = (state_q == S_INIT_ROW) || (state_q == S_INIT_COL) || (state_q == S_WRITE);
    a_addr = (state_q == S_LOAD) ? row_q - 4'd1 : '0;
    b_addr = (state_q == S_LOAD) ? col_q - 4'd1 : '0;
    wr_score = '0;
    wr_sym   = '0;
    case (state_q)
      S_INIT_ROW: begin
        wr_score = init_score;
        wr_sym   = (col_q == 4'd0) ? 3'b000 : 3'b001;
      end
      S_INIT_COL: begin
        wr_score = init_score;
        wr_sym   = 3'b010;
      end
      S_WRITE: begin
        wr_score = res_score_q;
        wr_sym   = res_sym_q;
      end
      default: ;
    endcase
  end

  assign row    = row_q;
  assign col    = col_q;
  assign m_diag = mdiag_q;
  assign m_up   = mup_q;
  assign m_lx   = mlx_q;
`ifdef NW_TIMEOUT_EN
  assign err    = err_q;
`endif

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// Bench for nw_fill_ctrl: memory/Max responder plus a cell-level model of the fill order,
// the expected write stream and the cycle budget; a reference NW matrix is checked after each fill.
`timescale 1ns/1ps
module tb_nw_fill_ctrl;
  localparam int N = 2;
  localparam int W = 9;
  localparam int MATCH = 1;
  localparam int MISMATCH = -1;
  localparam int GAP = -2;
  localparam int NCELL = N * N;
  localparam int TOTW = (N + 1) * (N + 1);
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, rd_en, value, wr_en;
  logic calculated = 1'b0;
  logic [3:0] row, col, a_addr, b_addr;
  logic signed [W-1:0] diag_s = '0, up_s = '0, lx_s = '0, max_v = '0;
  logic signed [W-1:0] m_diag, m_up, m_lx, wr_score;
  logic [1:0] char_a, char_b;
  logic [2:0] symbol = '0, wr_sym;
`ifdef NW_TIMEOUT_EN
  logic err;
`endif

  int total = 0, bad = 0;

  nw_fill_ctrl #(.N(N), .W(W), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .row(row), .col(col), .rd_en(rd_en),
    .diag_s(diag_s), .up_s(up_s), .lx_s(lx_s),
    .a_addr(a_addr), .b_addr(b_addr), .char_a(char_a), .char_b(char_b),
    .value(value), .m_diag(m_diag), .m_up(m_up), .m_lx(m_lx),
    .max(max_v), .symbol(symbol), .calculated(calculated),
    .wr_en(wr_en), .wr_score(wr_score), .wr_sym(wr_sym)
`ifdef NW_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  logic [1:0] sa [16];
  logic [1:0] sb [16];
  assign char_a = sa[a_addr];
  assign char_b = sb[b_addr];

  int mem  [N+1][N+1];
  int refm [N+1][N+1];

  // stimulus controls (written by the main sequence only)
  int lat_mode = 1;  // 0 random 0..3, 1 reply next cycle, 2 slow (3), 3 never
  int ovr = 0;       // force saturating neighbour values for cell (1,1)

  function automatic int sat(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + responder + per-cycle compare ----------------
  int run = 0, cyc = 0, wcnt = 0, cost = 0, lastw = -100;
  int hold = 0, req = 0, cd = 0, vcnt = 0, tmo = 0, err_exp = 0, dones = 0;
  int exd = 0, exu = 0, exl = 0, ret_s = 0;
  logic [2:0] ret_y = '0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    int exp_done, c, ci, cj, ei, ej, es, ey, md, mu, ml;
    exp_done = (run != 0 && wcnt == TOTW && cyc == lastw + 1) ? 1 : 0;
    chk("busy", int'(busy), run);
    chk("done", int'(done), exp_done);
`ifdef NW_TIMEOUT_EN
    chk("err", int'(err), err_exp);
    err_exp = 0;
`endif
    if (done) begin
      dones++;
      chk("done_cycle", cyc, 2 * N + 2 + cost);
    end
    if (rd_en || wr_en) chk("rd_wr_excl", int'(rd_en && wr_en), 0);

    if (wr_en) begin
      chk("wr_value_low", int'(value), 0);
      if (wcnt < TOTW) begin
        if (wcnt <= N) begin
          ei = 0; ej = wcnt; es = wcnt * GAP; ey = (wcnt == 0) ? 0 : 1;
        end else if (wcnt <= 2 * N) begin
          ei = wcnt - N; ej = 0; es = ei * GAP; ey = 2;
        end else begin
          c = wcnt - 2 * N - 1;
          ei = 1 + c / N; ej = 1 + c % N; es = ret_s; ey = int'(ret_y);
        end
        chk("wr_row", int'(row), ei);
        chk("wr_col", int'(col), ej);
        chk("wr_score", int'($signed(wr_score)), es);
        chk("wr_sym", int'(wr_sym), ey);
        mem[ei][ej] = int'($signed(wr_score));
      end else begin
        chk("wr_count", wcnt, TOTW - 1);
      end
      wcnt++;
      lastw = cyc;
    end

    if (rd_en) begin
      chk("rd_single", int'(prev_rd), 0);
      c = wcnt - (2 * N + 1);
      if (c < 0 || c >= NCELL) begin
        chk("rd_in_range", c, 0);
        c = 0;
      end
      ci = 1 + c / N; cj = 1 + c % N;
      chk("rd_row", int'(row), ci);
      chk("rd_col", int'(col), cj);
      if (ovr != 0 && ci == 1 && cj == 1) begin
        diag_s = W'(SMAX); up_s = W'(SMIN); lx_s = W'(-2);
      end else begin
        diag_s = W'(mem[ci-1][cj-1]); up_s = W'(mem[ci-1][cj]); lx_s = W'(mem[ci][cj-1]);
      end
      exd = sat(int'(diag_s) + ((sa[ci-1] == sb[cj-1]) ? MATCH : MISMATCH));
      exu = sat(int'(up_s) + GAP);
      exl = sat(int'(lx_s) + GAP);
      hold = 1;
    end else if (hold != 0) begin
      hold = 0;  // LOAD cycle: keep neighbours stable until its closing edge
    end else begin
      diag_s = W'($urandom); up_s = W'($urandom); lx_s = W'($urandom);
    end

    if (value) begin
      chk("m_diag", int'($signed(m_diag)), exd);
      chk("m_up", int'($signed(m_up)), exu);
      chk("m_lx", int'($signed(m_lx)), exl);
      if (req == 0) begin
        req = 1; vcnt = 0;
        case (lat_mode)
          0: cd = $urandom_range(0, 3);
          1: cd = 1;
          2: cd = 3;
          default: cd = 100000;
        endcase
        cost += 4 + ((cd < 1) ? 1 : cd);
      end
      vcnt++;
      if (vcnt == 16 && lat_mode == 3) tmo = 1;
      if (cd == 0) begin
        md = int'($signed(m_diag)); mu = int'($signed(m_up)); ml = int'($signed(m_lx));
        if (md >= mu && md >= ml) begin ret_s = md; ret_y = 3'b100; end
        else if (mu >= ml)        begin ret_s = mu; ret_y = 3'b010; end
        else                      begin ret_s = ml; ret_y = 3'b001; end
        calculated = 1'b1; max_v = W'(ret_s); symbol = ret_y;
      end else begin
        cd--;
        calculated = 1'b0; max_v = W'($urandom); symbol = 3'($urandom);
      end
    end else begin
      req = 0;
      calculated = 1'b0; max_v = W'($urandom); symbol = 3'($urandom);
    end
    prev_rd = rd_en;

    // state for the next cycle
    if (rst) begin
      run = 0; wcnt = 0; req = 0; hold = 0; tmo = 0; calculated = 1'b0;
    end else if (tmo != 0) begin
      run = 0; tmo = 0; req = 0; err_exp = 1;
    end else if (exp_done != 0) begin
      run = 0;
    end else if (run == 0 && start) begin
      run = 1; cyc = 0; wcnt = 0; cost = 0; lastw = -100;
    end
    if (run != 0) cyc++;
  end

  // ---------------- sequencing helpers ----------------
  int first_m [3];
  int init_log [5];
  int extra_starts = 0;

  task automatic run_fill(output int cnt);
    int seen_v, nw;
    seen_v = 0; nw = 0;
    @(posedge clk); #2 start = 1'b1;
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk); #1 cnt++;
      start = (extra_starts != 0) && (cnt == 4 || cnt == 12 || cnt == 20);
      if (value && seen_v == 0) begin
        seen_v = 1;
        first_m[0] = int'($signed(m_diag)); first_m[1] = int'($signed(m_up)); first_m[2] = int'($signed(m_lx));
      end
      if (wr_en && nw < 5) begin init_log[nw] = int'($signed(wr_score)); nw++; end
      if (done) break;
    end
    start = 1'b0;
    if (!done) chk("done_within_bound", 0, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctrl"}, int'({busy, done, rd_en, wr_en, value}), 0);
    chk({tag, "_idx"}, int'({row, col, a_addr, b_addr}), 0);
    chk({tag, "_data"}, int'(|{m_diag, m_up, m_lx, wr_score, wr_sym}), 0);
  endtask

  task automatic check_matrix();
    int d;
    for (int j = 0; j <= N; j++) refm[0][j] = j * GAP;
    for (int i = 1; i <= N; i++) refm[i][0] = i * GAP;
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        d = sat(refm[i-1][j-1] + ((sa[i-1] == sb[j-1]) ? MATCH : MISMATCH));
        if (sat(refm[i-1][j] + GAP) > d) d = sat(refm[i-1][j] + GAP);
        if (sat(refm[i][j-1] + GAP) > d) d = sat(refm[i][j-1] + GAP);
        refm[i][j] = d;
      end
    for (int i = 0; i <= N; i++)
      for (int j = 0; j <= N; j++) chk("matrix", mem[i][j], refm[i][j]);
  endtask

  task automatic randomize_seqs();
    for (int k = 0; k < 16; k++) begin sa[k] = 2'($urandom); sb[k] = 2'($urandom); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt, d0;
    randomize_seqs();
    for (int i = 0; i <= N; i++) for (int j = 0; j <= N; j++) mem[i][j] = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    #1 rst = 1'b0;

    // equal leading characters, Max replies the cycle after ISSUE
    sa[0] = 2'd1; sb[0] = 2'd1; lat_mode = 1;
    run_fill(cnt);
    chk("budget_N2", cnt, 26);
    chk("first_m_diag", first_m[0], 1);
    chk("first_m_up", first_m[1], -4);
    chk("first_m_lx", first_m[2], -4);
    chk("init0", init_log[0], 0);
    chk("init1", init_log[1], -2);
    chk("init2", init_log[2], -4);
    chk("init3", init_log[3], -2);
    chk("init4", init_log[4], -4);
    repeat (2) @(posedge clk);
    check_matrix();

    // random sequences and random Max latency
    lat_mode = 0;
    for (int r = 0; r < 5; r++) begin
      randomize_seqs();
      run_fill(cnt);
      repeat (2) @(posedge clk);
      check_matrix();
    end

    // saturation on the first cell
    lat_mode = 1; ovr = 1; sa[0] = 2'd2; sb[0] = 2'd2;
    run_fill(cnt);
    chk("sat_m_diag", first_m[0], 255);
    chk("sat_m_up", first_m[1], -256);
    chk("sat_m_lx", first_m[2], -4);
    ovr = 0;
    repeat (2) @(posedge clk);

    // start pulses while busy are ignored
    randomize_seqs();
    d0 = dones; extra_starts = 1;
    run_fill(cnt);
    extra_starts = 0;
    chk("budget_busy_start", cnt, 2 * N + 2 + 5 * N * N);
    repeat (30) @(posedge clk);
    chk("single_done", dones - d0, 1);

    // reset in WAIT of cell (1,2), then restart from (0,0)
    lat_mode = 2;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cnt = 0;
    while (cnt < 500 && !(value && row == 4'd1 && col == 4'd2)) begin
      @(posedge clk); #1 cnt++;
    end
    chk("reach_cell_1_2", int'(value && row == 4'd1 && col == 4'd2), 1);
    @(posedge clk); #1 chk("in_wait", int'(value), 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 check_reset_outs("midfill_reset");
    #1 rst = 1'b0;
    lat_mode = 1;
    run_fill(cnt);
    chk("budget_after_reset", cnt, 2 * N + 2 + 5 * N * N);
    repeat (2) @(posedge clk);
    check_matrix();

`ifdef NW_TIMEOUT_EN
    // Max unit never answers
    lat_mode = 3; d0 = dones;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cnt = 0;
    while (cnt < 500 && !err) begin
      @(posedge clk); #1 cnt++;
    end
    chk("err_seen", int'(err), 1);
    chk("err_value_low", int'(value), 0);
    chk("err_idle", int'(busy), 0);
    repeat (3) @(posedge clk);
    chk("err_no_done", dones - d0, 0);
    lat_mode = 1;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
